// File: rtl/stage_ex_muldiv.sv
// stage_ex_muldiv: execute-stage register with a single-cycle ALU and an
// iterative unit (radix-2 shift-add multiply, restoring unsigned divide).
// Build option: define STAGE_EX_MULDIV_DIV_EN to include the divider
// (ops 12/13); without it those ops are single-cycle and return 0.
// Handshake: while ex_busy is high upstream must hold its id_* fields;
// when ex_busy is low and flush is low every rising edge captures them.
module stage_ex_muldiv #(
    parameter int DATA_W   = 32,
    parameter int RF_SRC_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [3:0]          id_op,
    input  logic [DATA_W-1:0]   id_opa,
    input  logic [DATA_W-1:0]   id_opb,
    input  logic                id_memWE,
    input  logic [DATA_W-1:0]   id_memData,
    input  logic                id_rfWE,
    input  logic [4:0]          id_rfDst,
    input  logic [RF_SRC_W-1:0] id_rfSrc,
    input  logic [2:0]          id_branchType,
    input  logic [DATA_W-1:0]   id_branchDst,
    output logic                ex_valid,
    output logic                ex_busy,
    output logic [DATA_W-1:0]   ex_opResult,
    output logic                ex_memWE,
    output logic [DATA_W-1:0]   ex_memData,
    output logic                ex_rfWE,
    output logic [4:0]          ex_rfDst,
    output logic [RF_SRC_W-1:0] ex_rfSrc,
    output logic [DATA_W-1:0]   ex_branchDst,
    output logic                ex_branchPermit
);
    localparam int SH_W = $clog2(DATA_W);
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state, next_state;

    logic                r_valid, r_memWE, r_rfWE;
    logic [3:0]          r_op;
    logic [DATA_W-1:0]   r_opa, r_opb, r_memData, r_branchDst;
    logic [4:0]          r_rfDst;
    logic [RF_SRC_W-1:0] r_rfSrc;
    logic [2:0]          r_branchType;

    // acc: product / partial remainder; q_reg: multiplier / quotient;
    // b_reg: shifting multiplicand / divisor.
    logic [SH_W-1:0]   count;
    logic [DATA_W-1:0] acc, q_reg, b_reg;
    logic              capture, start;
    logic [DATA_W-1:0] alu_res, iter_res;
    logic              branch_cond;

    function automatic logic is_multi(input logic [3:0] op);
`ifdef STAGE_EX_MULDIV_DIV_EN
        return (op == 4'd11) || (op == 4'd12) || (op == 4'd13);
`else
        return (op == 4'd11);
`endif
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next state, stall and capture control; flush overrides everything.
    always_comb begin
        next_state = state;
        ex_busy    = (state == ITER);
        capture    = !ex_busy && !flush;
        start      = capture && id_valid && is_multi(id_op);
        case (state)
            IDLE, DONE: next_state = start ? ITER : IDLE;
            ITER:       next_state = (count == SH_W'(DATA_W - 1)) ? DONE : ITER;
            default:    next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    // EX pipeline register: cleared by reset/flush, held while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            r_valid <= 1'b0; r_op <= '0; r_opa <= '0; r_opb <= '0;
            r_memWE <= 1'b0; r_memData <= '0; r_rfWE <= 1'b0; r_rfDst <= '0;
            r_rfSrc <= '0; r_branchType <= '0; r_branchDst <= '0;
        end else if (capture) begin
            r_valid <= id_valid; r_op <= id_op; r_opa <= id_opa; r_opb <= id_opb;
            r_memWE <= id_memWE; r_memData <= id_memData; r_rfWE <= id_rfWE;
            r_rfDst <= id_rfDst; r_rfSrc <= id_rfSrc; r_branchType <= id_branchType;
            r_branchDst <= id_branchDst;
        end
    end

`ifdef STAGE_EX_MULDIV_DIV_EN
    logic [DATA_W:0] rem_shift, rem_diff;
    // One restoring-division step: shift in the next dividend bit and try to subtract.
    always_comb begin
        rem_shift = {acc, q_reg[DATA_W-1]};
        rem_diff  = rem_shift - {1'b0, b_reg};
    end
`endif

    // Iterative datapath: operands loaded at capture, one bit per ITER cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            count <= '0; acc <= '0; q_reg <= '0; b_reg <= '0;
        end else if (start) begin
            count <= '0;
            acc   <= '0;
            q_reg <= (id_op == OP_MUL) ? id_opb : id_opa;
            b_reg <= (id_op == OP_MUL) ? id_opa : id_opb;
        end else if (state == ITER) begin
            count <= count + SH_W'(1);
`ifdef STAGE_EX_MULDIV_DIV_EN
            if (r_op != OP_MUL) begin
                if (!rem_diff[DATA_W]) begin
                    acc   <= rem_diff[DATA_W-1:0];
                    q_reg <= {q_reg[DATA_W-2:0], 1'b1};
                end else begin
                    acc   <= rem_shift[DATA_W-1:0];
                    q_reg <= {q_reg[DATA_W-2:0], 1'b0};
                end
            end else
`endif
            begin
                if (q_reg[0]) acc <= acc + b_reg;
                b_reg <= b_reg << 1;
                q_reg <= q_reg >> 1;
            end
        end
    end

    // Single-cycle ALU on the EX register contents.
    always_comb begin
        alu_res = '0;
        case (r_op)
            4'd0:    alu_res = r_opa + r_opb;
            4'd1:    alu_res = r_opa - r_opb;
            4'd2:    alu_res = r_opa & r_opb;
            4'd3:    alu_res = r_opa | r_opb;
            4'd4:    alu_res = r_opb << r_opa[SH_W-1:0];
            4'd5:    alu_res = r_opb >> r_opa[SH_W-1:0];
            4'd6:    alu_res = $signed(r_opb) >>> r_opa[SH_W-1:0];
            4'd7:    alu_res = r_opa ^ r_opb;
            4'd8:    alu_res = ~(r_opa | r_opb);
            4'd9:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_opa) < $signed(r_opb))};
            4'd10:   alu_res = {{(DATA_W-1){1'b0}}, (r_opa < r_opb)};
            default: alu_res = '0;
        endcase
    end

    // Output stage: iterative result only in DONE, side effects suppressed in ITER.
    always_comb begin
        iter_res = acc;
`ifdef STAGE_EX_MULDIV_DIV_EN
        if (r_op == OP_DIVU) iter_res = q_reg;
`endif
        if (is_multi(r_op)) ex_opResult = (state == DONE) ? iter_res : '0;
        else                ex_opResult = alu_res;
        ex_valid     = (state == ITER) ? 1'b0 : ((state == DONE) ? 1'b1 : r_valid);
        ex_memWE     = r_memWE && (state != ITER);
        ex_rfWE      = r_rfWE && (state != ITER);
        ex_memData   = r_memData;
        ex_rfDst     = r_rfDst;
        ex_rfSrc     = r_rfSrc;
        ex_branchDst = r_branchDst;
        case (r_branchType)
            3'b001:  branch_cond = (ex_opResult == '0);
            3'b010:  branch_cond = (ex_opResult != '0);
            3'b011:  branch_cond = ex_opResult[DATA_W-1];
            3'b100:  branch_cond = !ex_opResult[DATA_W-1];
            default: branch_cond = 1'b0;
        endcase
        ex_branchPermit = ex_valid && branch_cond;
    end
endmodule

// File: tb/tb_stage_ex_muldiv.sv
// Directed bench for stage_ex_muldiv at DATA_W=32: ALU ops, branch gating,
// multicycle mul (and div/rem when the divider is built), flush and async reset.
module tb_stage_ex_muldiv;
  localparam int W = 32;
`ifdef STAGE_EX_MULDIV_DIV_EN
  localparam logic [3:0] FLUSH_OP = 4'd12;
`else
  localparam logic [3:0] FLUSH_OP = 4'd11;
`endif

  logic clk, rst, flush, id_valid, id_memWE, id_rfWE;
  logic [3:0] id_op;
  logic [W-1:0] id_opa, id_opb, id_memData, id_branchDst;
  logic [4:0] id_rfDst;
  logic [1:0] id_rfSrc;
  logic [2:0] id_branchType;
  logic ex_valid, ex_busy, ex_memWE, ex_rfWE, ex_branchPermit;
  logic [W-1:0] ex_opResult, ex_memData, ex_branchDst;
  logic [4:0] ex_rfDst;
  logic [1:0] ex_rfSrc;

  int checks = 0;
  int errors = 0;
  int n_busy;
  logic [W-1:0] exp_q[$];

  stage_ex_muldiv #(.DATA_W(W), .RF_SRC_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_op(id_op),
    .id_opa(id_opa), .id_opb(id_opb), .id_memWE(id_memWE), .id_memData(id_memData),
    .id_rfWE(id_rfWE), .id_rfDst(id_rfDst), .id_rfSrc(id_rfSrc),
    .id_branchType(id_branchType), .id_branchDst(id_branchDst),
    .ex_valid(ex_valid), .ex_busy(ex_busy), .ex_opResult(ex_opResult),
    .ex_memWE(ex_memWE), .ex_memData(ex_memData), .ex_rfWE(ex_rfWE),
    .ex_rfDst(ex_rfDst), .ex_rfSrc(ex_rfSrc), .ex_branchDst(ex_branchDst),
    .ex_branchPermit(ex_branchPermit)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_in(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2:0] bt);
    id_valid = v; id_op = op; id_opa = a; id_opb = b; id_branchType = bt;
    id_memWE = 1'b1; id_rfWE = 1'b1; id_rfDst = 5'd9; id_rfSrc = 2'b10;
    id_memData = 32'hA5A5_0000; id_branchDst = 32'h0000_0100;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_res(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty_queue expected=value", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'(ex_opResult), 64'(e));
    end
  endtask

  task automatic wait_busy_low();
    n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (!ex_busy) break;
      n_busy++;
      step();
    end
  endtask

  task automatic run_multi(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] expv);
    set_in(1'b1, op, a, b, 3'b000);
    step();
    wait_busy_low();
    check({tag, "_busy_cycles"}, 64'(n_busy), 64'd32);
    exp_q.push_back(expv);
    check_res(tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(ex_valid), 64'd0);
    check({tag, "_busy"}, 64'(ex_busy), 64'd0);
    check({tag, "_result"}, 64'(ex_opResult), 64'd0);
    check({tag, "_rfwe"}, 64'(ex_rfWE), 64'd0);
    check({tag, "_memwe"}, 64'(ex_memWE), 64'd0);
    check({tag, "_rfdst"}, 64'(ex_rfDst), 64'd0);
    check({tag, "_memdata"}, 64'(ex_memData), 64'd0);
    check({tag, "_permit"}, 64'(ex_branchPermit), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_in(1'b1, 4'd0, 32'd7, 32'd9, 3'b001);
    #1;
    check_all_zero("reset");
    step();
    check_all_zero("reset_held");
    rst = 1'b0;

    // add 7 + (-3)
    set_in(1'b1, 4'd0, 32'd7, 32'hFFFF_FFFD, 3'b000);
    step();
    exp_q.push_back(32'd4);
    check_res("add");
    check("add_valid", 64'(ex_valid), 64'd1);
    check("add_busy", 64'(ex_busy), 64'd0);
    check("add_rfdst", 64'(ex_rfDst), 64'd9);
    check("add_memdata", 64'(ex_memData), 64'hA5A5_0000);

    set_in(1'b1, 4'd6, 32'd4, 32'h8000_0000, 3'b000);
    step(); exp_q.push_back(32'hF800_0000); check_res("sra");
    set_in(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1, 3'b000);
    step(); exp_q.push_back(32'd1); check_res("slt");
    set_in(1'b1, 4'd10, 32'hFFFF_FFFF, 32'd1, 3'b000);
    step(); exp_q.push_back(32'd0); check_res("sltu");
    set_in(1'b1, 4'd4, 32'd36, 32'h0000_0003, 3'b000);
    step(); exp_q.push_back(32'h0000_0030); check_res("sll_wrap_amount");
    set_in(1'b1, 4'd8, 32'h0F0F_0000, 32'h0000_00F0, 3'b000);
    step(); exp_q.push_back(32'hF0F0_FF0F); check_res("nor");
    set_in(1'b1, 4'd14, 32'd3, 32'd4, 3'b000);
    step(); exp_q.push_back(32'd0); check_res("op14");

    // branch gating
    set_in(1'b1, 4'd1, 32'd5, 32'd5, 3'b001);
    step();
    check("beq_permit", 64'(ex_branchPermit), 64'd1);
    check("beq_bdst", 64'(ex_branchDst), 64'h100);
    set_in(1'b0, 4'd1, 32'd5, 32'd5, 3'b001);
    step();
    check("beq_invalid_permit", 64'(ex_branchPermit), 64'd0);

    // mul with next op waiting upstream
    set_in(1'b1, 4'd11, 32'h0001_0000, 32'h0001_0001, 3'b000);
    step();
    check("mul_iter_valid", 64'(ex_valid), 64'd0);
    check("mul_iter_rfwe", 64'(ex_rfWE), 64'd0);
    check("mul_iter_memwe", 64'(ex_memWE), 64'd0);
    set_in(1'b1, 4'd0, 32'd1, 32'd2, 3'b000);
    wait_busy_low();
    check("mul_busy_cycles", 64'(n_busy), 64'd32);
    exp_q.push_back(32'h0001_0000);
    check_res("mul_done");
    check("mul_done_valid", 64'(ex_valid), 64'd1);
    check("mul_done_rfwe", 64'(ex_rfWE), 64'd1);
    step();
    exp_q.push_back(32'd3);
    check_res("after_mul_add");
    check("after_mul_busy", 64'(ex_busy), 64'd0);

`ifdef STAGE_EX_MULDIV_DIV_EN
    run_multi("divu", 4'd12, 32'd100, 32'd7, 32'd14);
    run_multi("remu", 4'd13, 32'd100, 32'd7, 32'd2);
    run_multi("divu_by0", 4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_multi("remu_by0", 4'd13, 32'd5, 32'd0, 32'd5);
`else
    set_in(1'b1, 4'd12, 32'd100, 32'd7, 3'b000);
    step();
    exp_q.push_back(32'd0);
    check_res("divu_disabled");
    check("divu_disabled_busy", 64'(ex_busy), 64'd0);
    check("divu_disabled_valid", 64'(ex_valid), 64'd1);
    run_multi("mul_b", 4'd11, 32'd12345, 32'd1000, 32'd12345000);
`endif

    // flush at iteration 10
    set_in(1'b1, FLUSH_OP, 32'd100, 32'd7, 3'b000);
    step();
    repeat (10) step();
    check("flush_pre_busy", 64'(ex_busy), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_all_zero("flush");
    set_in(1'b1, 4'd0, 32'd20, 32'd22, 3'b000);
    step();
    exp_q.push_back(32'd42);
    check_res("after_flush_add");

    // async reset mid-mul
    set_in(1'b1, 4'd11, 32'd3, 32'd5, 3'b000);
    step();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    rst = 1'b0;
    set_in(1'b1, 4'd0, 32'd10, 32'd20, 3'b000);
    step();
    exp_q.push_back(32'd30);
    check_res("after_rst_add");
    check("after_rst_valid", 64'(ex_valid), 64'd1);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stage_ex_muldiv.md
STAGE_EX_MULDIV -- requirements
Module: stage_ex_muldiv

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, datapath width; legal values are 16, 32 and 64.
REQ-002 The block SHALL have parameter RF_SRC_W, default 2, writeback-source select width.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port flush  input  1  synchronous kill of the EX slot.
REQ-006 The block SHALL have port id_valid  input  1  ID slot holds an instruction.
REQ-007 The block SHALL have ports id_op  input  4, and id_opa and id_opb  input  DATA_W; these carry the ALU opcode and operands.
REQ-008 The block SHALL have ports id_memWE  input  1, and id_memData  input  DATA_W; these are pass-through fields.
REQ-009 The block SHALL have ports id_rfWE  input  1, id_rfDst  input  5, and id_rfSrc  input  RF_SRC_W; these are pass-through fields.
REQ-010 The block SHALL have ports id_branchType  input  3, and id_branchDst  input  DATA_W.
REQ-011 The block SHALL have port ex_valid  output  1  EX result final this cycle.
REQ-012 The block SHALL have port ex_busy  output  1  stall request to IF/ID; upstream holds while it is high.
REQ-013 The block SHALL have outputs ex_opResult, ex_memWE, ex_memData, ex_rfWE, ex_rfDst, ex_rfSrc, ex_branchDst (widths matching inputs), and ex_branchPermit  output  1.

Function
REQ-014 The EX register SHALL capture all id_* fields on a clock edge when ex_busy=0 and flush=0, and SHALL hold them while ex_busy=1.
REQ-015 When flush=1 at an edge, the EX register SHALL load all-zero, ex_valid SHALL go to 0, and any iteration in progress SHALL be aborted to IDLE; flush has priority over busy.
REQ-016 Single-cycle ops SHALL be: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 srl, 6 sra, 7 xor, 8 nor, 9 slt (signed, result 1/0), 10 sltu. Shift amount SHALL be opa[log2(DATA_W)-1:0], and the shifted value SHALL be opb.
REQ-017 Multicycle ops SHALL be: 11 mul (low DATA_W bits of product), 12 divu quotient, 13 remu remainder; ops 14-15 SHALL give result 0.
REQ-018 The result of a single-cycle op SHALL be combinational from the EX register, with ex_valid = captured id_valid and ex_busy=0.
REQ-019 The FSM states SHALL be IDLE, ITER, and DONE. A captured multicycle op with valid=1 SHALL enter ITER with count=0 and SHALL run radix-2 shift-add or restoring division, one bit per cycle.
REQ-020 ITER SHALL last exactly DATA_W cycles, then pass to DONE. DONE SHALL last 1 cycle, then return to IDLE (or ITER if the next captured op is also multicycle).
REQ-021 ex_busy SHALL be 1 whenever EX holds a valid multicycle op not yet in DONE, including the capture cycle. A multicycle op therefore occupies EX for DATA_W+1 cycles.
REQ-022 In ITER, ex_valid, ex_rfWE, ex_memWE and ex_branchPermit SHALL be forced to 0.
REQ-023 In DONE, ex_opResult SHALL be the iterative result and ex_valid SHALL be 1.
REQ-024 Divide by zero SHALL produce quotient all-ones and remainder = opa, with no exception.
REQ-025 ex_branchPermit SHALL be gated by ex_valid and SHALL follow branchType: 000 none, 001 result==0, 010 result!=0, 011 result[DATA_W-1]=1, 100 result[DATA_W-1]=0, others 0.

Reset
REQ-026 rst=1 SHALL immediately clear the EX register, FSM to IDLE, count 0, and accumulators 0. As a result, every output SHALL read 0, including ex_busy, ex_valid and ex_branchPermit.
REQ-027 Assertion of rst mid-iteration SHALL abandon the operation; after release, the first edge SHALL capture normally.

Configuration
REQ-028 The macro SHALL be STAGE_EX_MULDIV_DIV_EN. When it is defined, ops 12-13 SHALL behave as in REQ-017 to REQ-024.
REQ-029 When STAGE_EX_MULDIV_DIV_EN is undefined, ops 12-13 SHALL be single-cycle with result 0, SHALL never assert ex_busy, and no divider logic SHALL be synthesized; mul SHALL be unaffected.

Verification
REQ-030 The bench SHALL cover: DATA_W=32, add 7+(-3) -> result 4, ex_valid=1 in the cycle after capture, ex_busy=0.
REQ-031 The bench SHALL cover: sra opa=4, opb=0x80000000 -> 0xF8000000; slt opa=-1, opb=1 -> 1; sltu with the same operands -> 0.
REQ-032 The bench SHALL cover: mul 0x10000 x 0x10001 -> ex_busy high for 32 cycles, then ex_valid=1 with result 0x00010000 in DONE, and the next op captured on the following edge.
REQ-033 The bench SHALL cover, with STAGE_EX_MULDIV_DIV_EN defined: divu 100/7 -> 14; remu 100/7 -> 2; divu 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5.
REQ-034 The bench SHALL cover: flush at iteration cycle 10 of a divu -> ex_busy=0 and all outputs 0 on the next cycle; separately, async rst pulse mid-mul -> outputs 0 without waiting for a clock edge.
REQ-035 The bench SHALL cover: beq sub 5-5 with branchType 001 -> ex_branchPermit=1; the same case with id_valid=0 -> ex_branchPermit=0.
